// File: rtl/lane_mod_pkg.sv
// Shared defaults, FSM state encoding and lane vector type for the lane
// modulo/divide unit.
package lane_mod_pkg;

   localparam int LANES_DEF = 6;
   localparam int W_DEF     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [LANES_DEF-1:0][W_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/lane_mod_step.sv
// One restoring-division step for a single lane: shift in the next dividend
// bit, then subtract the divisor if it fits.
module lane_mod_step
   import lane_mod_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] rem,
   input  logic         dvd_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0] trial;

   // A zero divisor always "fits", so the remainder rebuilds the dividend
   // and every quotient bit comes out as 1.
   always_comb begin
      trial    = {rem, dvd_bit};
      q_bit    = (trial >= {1'b0, divisor});
      rem_next = q_bit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
   end

endmodule

// File: rtl/lane_mod_unit.sv
// Multi-lane restoring divider: W iterations produce per-lane remainder,
// quotient and divide-by-zero flags.
//
//   state | meaning
//   IDLE  | waiting for start; results hold
//   CALC  | one division step per cycle in every lane, W cycles
//   DONE  | results valid, done pulse; returns to IDLE
module lane_mod_unit
   import lane_mod_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [LANES-1:0][W-1:0] vector,
   input  logic [LANES-1:0][W-1:0] modulus,
   output logic                    busy,
   output logic                    done,
   output logic [LANES-1:0][W-1:0] remainder,
   output logic [LANES-1:0][W-1:0] quotient,
   output logic [LANES-1:0]        ModFlags
);

   localparam int            CW   = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [LANES-1:0][W-1:0] dvd_q;
   logic [LANES-1:0][W-1:0] dsr_q;
   logic [LANES-1:0][W-1:0] rem_q;
   logic [LANES-1:0][W-1:0] rem_nx;
   logic [LANES-1:0]        qbit;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_mod_step #(.W(W)) u_step (
         .rem      (rem_q[g]),
         .dvd_bit  (dvd_q[g][W-1]),
         .divisor  (dsr_q[g]),
         .rem_next (rem_nx[g]),
         .q_bit    (qbit[g])
      );
   end

   // The dividend register shifts left each step and quotient bits enter at
   // the LSB, so after W steps it holds the quotient.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remainder <= '0;
         quotient  <= '0;
         ModFlags  <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dvd_q <= vector;
                  dsr_q <= modulus;
                  rem_q <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               cnt   <= cnt + CW'(1);
               for (int i = 0; i < LANES; i++) begin
                  dvd_q[i] <= {dvd_q[i][W-2:0], qbit[i]};
               end
               if (cnt == LAST) begin
                  remainder <= rem_nx;
                  for (int i = 0; i < LANES; i++) begin
                     quotient[i] <= {dvd_q[i][W-2:0], qbit[i]};
                     ModFlags[i] <= (dsr_q[i] == '0);
                  end
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
